inbox_fifo: RTL and testbench
=============================

INBOX_FIFO -- requirements
Module: inbox_fifo

Interface
REQ-001 Parameter: DEPTH, 16, number of 8-bit entries; power of two, minimum 2.
REQ-002 Parameter: AW, log2(DEPTH), pointer width; count width is AW+1.
REQ-003 Clocking and reset: one clock; reset is asynchronous and active-low.
REQ-004 clk  input  1  sole clock; all state changes on the rising edge.
REQ-005 i_rst_n  input  1  asynchronous active-low reset.
REQ-006 i_wr  input  1  write strobe from the external loader (keypad/host/preload).
REQ-007 i_data  input  8  write data, sampled when i_wr=1.
REQ-008 rIn  input  1  read/pop strobe from the control unit (asserted in its INBOX state).
REQ-009 i_clr  input  1  synchronous flush.
REQ-010 o_data  output  8  head entry, first-word-fall-through, valid while o_empty=0.
REQ-011 o_empty  output  1  queue empty; drives the control unit's inEmpty.
REQ-012 o_full  output  1  queue holds DEPTH entries.
REQ-013 o_count  output  AW+1  number of stored entries, 0..DEPTH.
REQ-014 o_err  output  1  sticky protocol-error flag (see Configuration).

Function
REQ-015 Storage SHALL be a DEPTH x 8 array with AW-bit read and write pointers wrapping modulo DEPTH, and a registered AW+1-bit count.
REQ-016 Write acceptance: i_wr=1 and (count<DEPTH, or count==DEPTH with rIn=1 in the same cycle); the accepted byte is stored at wptr and wptr increments.
REQ-017 Pop acceptance: rIn=1 and count>0; rptr increments, and the popped value is the o_data presented during that cycle.
REQ-018 Count update: +1 on write only, -1 on pop only, unchanged on simultaneous accepted write and pop.
REQ-019 Write while empty with rIn=1 in the same cycle: write accepted, pop ignored (no bypass); o_empty deasserts on the next cycle.
REQ-020 Write while full without rIn: data dropped; pointers and count unchanged.
REQ-021 Pop while empty: ignored; pointers and count unchanged.
REQ-022 Latency: a written byte appears on o_data, and o_empty falls, exactly one clock after the accepting edge when the queue was empty.
REQ-023 o_empty = (count==0); o_full = (count==DEPTH); o_count = count. All derive from registered state only, with no combinational path from i_wr or rIn.
REQ-024 o_data = mem[rptr], combinational from registered state; its value while o_empty=1 is don't-care.
REQ-025 i_clr=1 SHALL set rptr, wptr and count to 0 on the next edge, overriding any write or pop in the same cycle.
REQ-026 Entries SHALL be delivered in strict write order across pointer wrap-around.

Reset
REQ-027 i_rst_n=0 SHALL immediately, without waiting for clk, force rptr=0, wptr=0, count=0 and o_err=0, giving o_empty=1, o_full=0, o_count=0.
REQ-028 Array contents SHALL NOT be reset.
REQ-029 Reset asserted mid-operation SHALL discard all queued entries.
REQ-030 Release is synchronous to clk; the first write is accepted on the first rising edge with i_rst_n=1.

Configuration
REQ-031 Macro INBOX_ERR_FLAG_EN defined: o_err SHALL set on the edge after a dropped write (REQ-020) or an ignored pop (REQ-021), and SHALL stay set until i_clr or reset.
REQ-032 Macro INBOX_ERR_FLAG_EN undefined: o_err SHALL be constant 0, with no error register present; all other behaviour is identical.

Verification
REQ-033 Reset, write 0x05, 0x0A, 0xFF, then pop three times -> o_data reads 0x05, 0x0A, 0xFF in order; o_empty=1 and o_count=0 after the third pop.
REQ-034 DEPTH=16: write 16 bytes 0x00..0x0F -> o_full=1, o_count=16; a 17th write of 0xAA is dropped; 16 pops return 0x00..0x0F; with the macro defined, o_err=1.
REQ-035 Fill to 16, then write 0x77 with rIn=1 in the same cycle -> count stays 16, head advances to 0x01, and 0x77 is the last of 16 pops.
REQ-036 Empty queue: i_wr=1 with 0x33 and rIn=1 together -> count=1 next cycle, o_data=0x33; with the macro defined, o_err remains 0.
REQ-037 Perform 40 write/pop pairs with 3 entries resident -> ordering intact through pointer wrap, and count never exceeds 4.
REQ-038 Hold 5 entries, pulse i_rst_n low between clock edges -> o_empty=1 and o_count=0 immediately; with 5 entries, i_clr=1 plus i_wr=1 -> count=0 next cycle.

Source files
------------

// File: rtl/inbox_fifo.sv
// ---------------------------------------------------------------------------
// inbox_fifo -- byte inbox queue between an external loader and the control
// unit. First-word-fall-through: the head entry is always visible on o_data,
// and the control unit pops it by asserting rIn.
//
// Ports
//   clk       sole clock, rising edge
//   i_rst_n   asynchronous active-low reset (pointers, count, error flag)
//   i_wr      write strobe from the loader
//   i_data    write byte, sampled with i_wr
//   rIn       pop strobe from the control unit
//   i_clr     synchronous flush, overrides write and pop in the same cycle
//   o_data    head entry (don't-care while o_empty=1)
//   o_empty   queue empty
//   o_full    queue holds DEPTH entries
//   o_count   number of stored entries, 0..DEPTH
//   o_err     sticky protocol-error flag
//
// Configuration macro
//   INBOX_ERR_FLAG_EN  when defined, o_err sets on a dropped write (full, no
//                      pop) or an ignored pop (empty, no write) and holds
//                      until i_clr or reset. Undefined: o_err is tied to 0.
// ---------------------------------------------------------------------------
module inbox_fifo #(
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          i_rst_n,
  input  logic          i_wr,
  input  logic [7:0]    i_data,
  input  logic          rIn,
  input  logic          i_clr,
  output logic [7:0]    o_data,
  output logic          o_empty,
  output logic          o_full,
  output logic [AW:0]   o_count,
  output logic          o_err
);

  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  // Storage is intentionally not reset; only the bookkeeping is.
  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] rptr_q, rptr_d;
  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW:0]   cnt_q,  cnt_d;

  logic empty, full, wr_ok, rd_ok;

  assign empty = (cnt_q == '0);
  assign full  = (cnt_q == FULL_CNT);

  // A write into a full queue is still accepted when the same cycle pops,
  // since the pop frees the slot the write lands in (wptr == rptr when full).
  assign wr_ok = i_wr & (~full | rIn);
  // No bypass: a pop on an empty queue is ignored even if a write arrives.
  assign rd_ok = rIn & ~empty;

  always_comb begin
    rptr_d = rptr_q;
    wptr_d = wptr_q;
    cnt_d  = cnt_q;
    if (i_clr) begin
      rptr_d = '0;
      wptr_d = '0;
      cnt_d  = '0;
    end else begin
      if (wr_ok) wptr_d = wptr_q + AW'(1);
      if (rd_ok) rptr_d = rptr_q + AW'(1);
      case ({wr_ok, rd_ok})
        2'b10:   cnt_d = cnt_q + (AW+1)'(1);
        2'b01:   cnt_d = cnt_q - (AW+1)'(1);
        default: cnt_d = cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rptr_q <= '0;
      wptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      rptr_q <= rptr_d;
      wptr_q <= wptr_d;
      cnt_q  <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_ok && !i_clr) mem_q[wptr_q] <= i_data;
  end

  assign o_data  = mem_q[rptr_q];
  assign o_empty = empty;
  assign o_full  = full;
  assign o_count = cnt_q;

`ifdef INBOX_ERR_FLAG_EN
  logic err_q, err_d;
  logic drop_wr, bad_pop;

  assign drop_wr = i_wr & full & ~rIn;
  // Pop on empty that coincides with a write is the normal no-bypass case,
  // not a protocol error.
  assign bad_pop = rIn & empty & ~i_wr;

  always_comb begin
    err_d = err_q | drop_wr | bad_pop;
    if (i_clr) err_d = 1'b0;
  end

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) err_q <= 1'b0;
    else          err_q <= err_d;
  end

  assign o_err = err_q;
`else
  assign o_err = 1'b0;
`endif

endmodule

// File: tb/tb_inbox_fifo.sv
// Directed bench for inbox_fifo (DEPTH=16). Inputs change 1ns after the
// rising edge; outputs are checked there too, away from the edge.
module tb_inbox_fifo;

`ifdef INBOX_ERR_FLAG_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       i_rst_n = 1'b0;
  logic       i_wr = 1'b0;
  logic [7:0] i_data = '0;
  logic       rIn = 1'b0;
  logic       i_clr = 1'b0;
  logic [7:0] o_data;
  logic       o_empty, o_full, o_err;
  logic [4:0] o_count;

  int n_tests = 0;
  int n_fail  = 0;

  inbox_fifo #(.DEPTH(16)) dut (
    .clk(clk), .i_rst_n(i_rst_n), .i_wr(i_wr), .i_data(i_data), .rIn(rIn),
    .i_clr(i_clr), .o_data(o_data), .o_empty(o_empty), .o_full(o_full),
    .o_count(o_count), .o_err(o_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_wr(input logic [7:0] d);
    i_wr = 1'b1; i_data = d;
    tick();
    i_wr = 1'b0;
  endtask

  task automatic do_pop(input string tag, input logic [7:0] exp);
    rIn = 1'b1;
    chk(tag, int'(o_data), int'(exp));
    tick();
    rIn = 1'b0;
  endtask

  task automatic do_clr();
    i_clr = 1'b1;
    tick();
    i_clr = 1'b0;
  endtask

  initial begin
    // Reset state, checked while reset is still asserted (no clock needed).
    #3;
    chk("rst_empty", int'(o_empty), 1);
    chk("rst_full",  int'(o_full),  0);
    chk("rst_count", int'(o_count), 0);
    chk("rst_err",   int'(o_err),   0);
    #10 i_rst_n = 1'b1;
    tick();

    // Basic ordering and first-write latency.
    do_wr(8'h05);
    chk("lat_empty", int'(o_empty), 0);
    chk("lat_data",  int'(o_data),  'h05);
    do_wr(8'h0A);
    do_wr(8'hFF);
    chk("b3_count", int'(o_count), 3);
    do_pop("b3_pop0", 8'h05);
    do_pop("b3_pop1", 8'h0A);
    do_pop("b3_pop2", 8'hFF);
    chk("b3_empty", int'(o_empty), 1);
    chk("b3_count0", int'(o_count), 0);

    // Fill to full, drop the 17th write, drain.
    for (int i = 0; i < 16; i++) do_wr(8'(i));
    chk("full_flag",  int'(o_full),  1);
    chk("full_count", int'(o_count), 16);
    chk("full_err0",  int'(o_err),   0);
    do_wr(8'hAA);
    chk("drop_count", int'(o_count), 16);
    chk("drop_err",   int'(o_err),   ERR_EN ? 1 : 0);
    chk("drop_head",  int'(o_data),  'h00);
    for (int i = 0; i < 16; i++) do_pop("drain", 8'(i));
    chk("drain_empty", int'(o_empty), 1);
    chk("err_sticky",  int'(o_err),   ERR_EN ? 1 : 0);
    do_clr();
    chk("err_clr", int'(o_err), 0);

    // Full with simultaneous write and pop.
    for (int i = 0; i < 16; i++) do_wr(8'(i));
    i_wr = 1'b1; i_data = 8'h77;
    do_pop("wp_head", 8'h00);
    i_wr = 1'b0;
    chk("wp_count", int'(o_count), 16);
    chk("wp_err",   int'(o_err),   0);
    for (int i = 1; i < 16; i++) do_pop("wp_drain", 8'(i));
    do_pop("wp_last", 8'h77);
    chk("wp_empty", int'(o_empty), 1);

    // Write and pop together on an empty queue: no bypass.
    i_wr = 1'b1; i_data = 8'h33; rIn = 1'b1;
    tick();
    i_wr = 1'b0; rIn = 1'b0;
    chk("nb_count", int'(o_count), 1);
    chk("nb_data",  int'(o_data),  'h33);
    chk("nb_err",   int'(o_err),   0);
    do_pop("nb_pop", 8'h33);

    // 40 write/pop pairs with 3 resident entries, across pointer wrap.
    for (int i = 0; i < 3; i++) do_wr(8'(8'h40 + i));
    for (int i = 0; i < 40; i++) begin
      i_wr = 1'b1; i_data = 8'(8'h43 + i);
      do_pop("wrap_head", 8'(8'h40 + i));
      i_wr = 1'b0;
      chk("wrap_count", int'(o_count), 3);
    end
    for (int i = 40; i < 43; i++) do_pop("wrap_tail", 8'(8'h40 + i));
    chk("wrap_empty", int'(o_empty), 1);

    // Pop on empty with no write.
    rIn = 1'b1;
    tick();
    rIn = 1'b0;
    chk("pe_count", int'(o_count), 0);
    chk("pe_err",   int'(o_err),   ERR_EN ? 1 : 0);
    do_clr();

    // Asynchronous reset mid-operation.
    for (int i = 0; i < 5; i++) do_wr(8'(8'h90 + i));
    chk("ar_pre", int'(o_count), 5);
    #2 i_rst_n = 1'b0;
    #1;
    chk("ar_empty", int'(o_empty), 1);
    chk("ar_count", int'(o_count), 0);
    #1 i_rst_n = 1'b1;
    do_wr(8'h5C);
    chk("ar_first_wr", int'(o_count), 1);
    chk("ar_first_dt", int'(o_data),  'h5C);

    // Flush overrides a concurrent write.
    for (int i = 0; i < 4; i++) do_wr(8'(i));
    chk("cl_pre", int'(o_count), 5);
    i_clr = 1'b1; i_wr = 1'b1; i_data = 8'hEE;
    tick();
    i_clr = 1'b0; i_wr = 1'b0;
    chk("cl_count", int'(o_count), 0);
    chk("cl_empty", int'(o_empty), 1);
    do_wr(8'h12);
    chk("cl_after", int'(o_data), 'h12);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
